// File: rtl/pcd8544_spi_receiver_pkg.sv
// Shared definitions for the PCD8544 serial receiver: opcode masks/patterns,
// default display geometry and the byte-assembly FSM state type.
package pcd8544_pkg;

    localparam int PCD_COLS = 84;
    localparam int PCD_ROWS = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } pcd_state_t;

    // Each opcode matches when (byte & MASK) == PAT
    localparam logic [7:0] NOP_MASK      = 8'hFF;
    localparam logic [7:0] NOP_PAT       = 8'h00;
    localparam logic [7:0] FUNC_SET_MASK = 8'hF8;
    localparam logic [7:0] FUNC_SET_PAT  = 8'h20;
    localparam logic [7:0] DISP_CTL_MASK = 8'hFA;
    localparam logic [7:0] DISP_CTL_PAT  = 8'h08;
    localparam logic [7:0] SET_Y_MASK    = 8'hF8;
    localparam logic [7:0] SET_Y_PAT     = 8'h40;
    localparam logic [7:0] SET_X_MASK    = 8'h80;
    localparam logic [7:0] SET_X_PAT     = 8'h80;
    localparam logic [7:0] TEMP_CTL_MASK = 8'hFC;
    localparam logic [7:0] TEMP_CTL_PAT  = 8'h04;
    localparam logic [7:0] BIAS_MASK     = 8'hF8;
    localparam logic [7:0] BIAS_PAT      = 8'h10;
    localparam logic [7:0] VOP_MASK      = 8'h80;
    localparam logic [7:0] VOP_PAT       = 8'h80;

    function automatic logic op_match(input logic [7:0] b,
                                      input logic [7:0] mask,
                                      input logic [7:0] pat);
        return (b & mask) == pat;
    endfunction

endpackage

// File: rtl/pcd8544_spi_receiver_if.sv
// Four-wire PCD8544 serial bus; the LCD configuration master drives it,
// the receiver samples it.
interface pcd8544_spi_receiver_if;
    logic sclk;
    logic mosi;
    logic sce;
    logic dc;

    modport master (output sclk, output mosi, output sce, output dc);
    modport slave  (input  sclk, input  mosi, input  sce, input  dc);
endinterface

// File: rtl/pcd8544_spi_receiver_spi_in_sync.sv
// Synchronises sclk/mosi/sce/dc into the system clock domain and flags
// sclk rising edges that occur while the synced chip enable is low.
module spi_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sclk,
    input  logic i_mosi,
    input  logic i_sce,
    input  logic i_dc,
    output logic o_mosi_s,
    output logic o_sce_s,
    output logic o_dc_s,
    output logic o_sclk_rise
);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_sce_sync;
    logic [SYNC_STAGES-1:0] r_dc_sync;
    logic                   r_sclk_prev;

    // sce resets high so nothing is counted until the master selects us
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_sce_sync  <= '1;
            r_dc_sync   <= '0;
            r_sclk_prev <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sce_sync  <= {r_sce_sync[SYNC_STAGES-2:0],  i_sce};
            r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0],   i_dc};
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
        end
    end

    assign o_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign o_sce_s     = r_sce_sync[SYNC_STAGES-1];
    assign o_dc_s      = r_dc_sync[SYNC_STAGES-1];
    assign o_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev & ~o_sce_s;

endmodule

// File: rtl/pcd8544_spi_receiver.sv
// Slave-side PCD8544 (Nokia 5110) serial receiver: byte assembly, command decode
// and display-RAM write strobes. Define PCD_FRAME_DONE_EN to enable o_frame_done.
module pcd8544_spi_receiver
    import pcd8544_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int COLS        = PCD_COLS,
    parameter int ROWS        = PCD_ROWS
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    pcd8544_spi_receiver_if.slave spi,
    output logic [7:0]            o_rx_byte,
    output logic                  o_rx_valid,
    output logic                  o_rx_is_data,
    output logic                  o_ram_we,
    output logic [8:0]            o_ram_addr,
    output logic [7:0]            o_ram_wdata,
    output logic                  o_pd,
    output logic                  o_v_mode,
    output logic                  o_h_ext,
    output logic [1:0]            o_disp_mode,
    output logic [6:0]            o_vop,
    output logic [2:0]            o_bias,
    output logic [1:0]            o_tc,
    output logic [6:0]            o_cur_x,
    output logic [2:0]            o_cur_y,
    output logic                  o_frame_done
);

    localparam logic [6:0] LP_X_LAST = 7'(COLS - 1);
    localparam logic [2:0] LP_Y_LAST = 3'(ROWS - 1);

    logic w_mosi_s;
    logic w_sce_s;
    logic w_dc_s;
    logic w_sclk_rise;

    spi_in_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk       (i_clock),
        .i_rst       (i_reset),
        .i_sclk      (spi.sclk),
        .i_mosi      (spi.mosi),
        .i_sce       (spi.sce),
        .i_dc        (spi.dc),
        .o_mosi_s    (w_mosi_s),
        .o_sce_s     (w_sce_s),
        .o_dc_s      (w_dc_s),
        .o_sclk_rise (w_sclk_rise)
    );

    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_shift;
    logic [7:0]  r_rx_byte;
    logic        r_rx_is_data;
    pcd_state_t  r_state;
    pcd_state_t  w_next_state;
    logic        w_byte_done;
    logic        w_done;

    assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7);
    assign w_done      = (r_state == DONE);

    // A deselect drops any partial byte; the counter wraps naturally after bit 7
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_rx_byte    <= '0;
            r_rx_is_data <= 1'b0;
        end else if (w_sce_s) begin
            r_bit_cnt <= '0;
        end else if (w_sclk_rise) begin
            r_shift   <= {r_shift[5:0], w_mosi_s};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_byte_done) begin
                r_rx_byte    <= {r_shift, w_mosi_s};
                r_rx_is_data <= w_dc_s;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_byte_done)  w_next_state = DONE;
                else if (!w_sce_s) w_next_state = SHIFT;
            end
            SHIFT: begin
                if (w_byte_done)  w_next_state = DONE;
                else if (w_sce_s) w_next_state = IDLE;
            end
            DONE: begin
                w_next_state = w_sce_s ? IDLE : SHIFT;
            end
            default: w_next_state = IDLE;
        endcase
    end

    logic       r_pd;
    logic       r_v_mode;
    logic       r_h_ext;
    logic [1:0] r_disp_mode;
    logic [6:0] r_vop;
    logic [2:0] r_bias;
    logic [1:0] r_tc;
    logic [6:0] r_cur_x;
    logic [2:0] r_cur_y;
    logic       w_x_last;
    logic       w_y_last;
    logic [8:0] w_addr;

    assign w_x_last = (r_cur_x == LP_X_LAST);
    assign w_y_last = (r_cur_y == LP_Y_LAST);
    assign w_addr   = 9'(r_cur_y) * 9'(COLS) + 9'(r_cur_x);

    // Commands take effect at the end of the DONE cycle; data bumps the cursor
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pd        <= 1'b1;
            r_v_mode    <= 1'b0;
            r_h_ext     <= 1'b0;
            r_disp_mode <= '0;
            r_vop       <= '0;
            r_bias      <= '0;
            r_tc        <= '0;
            r_cur_x     <= '0;
            r_cur_y     <= '0;
        end else if (w_done && !r_rx_is_data) begin
            if (op_match(r_rx_byte, SET_X_MASK, SET_X_PAT)) begin
                if (r_h_ext) begin
                    r_vop <= r_rx_byte[6:0];
                end else if (int'(r_rx_byte[6:0]) < COLS) begin
                    r_cur_x <= r_rx_byte[6:0];
                end
            end else if (op_match(r_rx_byte, SET_Y_MASK, SET_Y_PAT)) begin
                if (!r_h_ext && (int'(r_rx_byte[2:0]) < ROWS)) begin
                    r_cur_y <= r_rx_byte[2:0];
                end
            end else if (op_match(r_rx_byte, FUNC_SET_MASK, FUNC_SET_PAT)) begin
                r_pd     <= r_rx_byte[2];
                r_v_mode <= r_rx_byte[1];
                r_h_ext  <= r_rx_byte[0];
            end else if (op_match(r_rx_byte, BIAS_MASK, BIAS_PAT)) begin
                if (r_h_ext) r_bias <= r_rx_byte[2:0];
            end else if (op_match(r_rx_byte, DISP_CTL_MASK, DISP_CTL_PAT)) begin
                if (!r_h_ext) r_disp_mode <= {r_rx_byte[2], r_rx_byte[0]};
            end else if (op_match(r_rx_byte, TEMP_CTL_MASK, TEMP_CTL_PAT)) begin
                if (r_h_ext) r_tc <= r_rx_byte[1:0];
            end
        end else if (w_done && r_rx_is_data) begin
            if (!r_v_mode) begin
                if (w_x_last) begin
                    r_cur_x <= '0;
                    r_cur_y <= w_y_last ? 3'd0 : r_cur_y + 3'd1;
                end else begin
                    r_cur_x <= r_cur_x + 7'd1;
                end
            end else begin
                if (w_y_last) begin
                    r_cur_y <= '0;
                    r_cur_x <= w_x_last ? 7'd0 : r_cur_x + 7'd1;
                end else begin
                    r_cur_y <= r_cur_y + 3'd1;
                end
            end
        end
    end

`ifdef PCD_FRAME_DONE_EN
    logic r_frame_done;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_done && r_rx_is_data && w_x_last && w_y_last;
        end
    end

    assign o_frame_done = r_frame_done;
`else
    assign o_frame_done = 1'b0;
`endif

    assign o_rx_byte    = r_rx_byte;
    assign o_rx_valid   = w_done;
    assign o_rx_is_data = r_rx_is_data;
    assign o_ram_we     = w_done && r_rx_is_data;
    assign o_ram_addr   = w_addr;
    assign o_ram_wdata  = r_rx_byte;
    assign o_pd         = r_pd;
    assign o_v_mode     = r_v_mode;
    assign o_h_ext      = r_h_ext;
    assign o_disp_mode  = r_disp_mode;
    assign o_vop        = r_vop;
    assign o_bias       = r_bias;
    assign o_tc         = r_tc;
    assign o_cur_x      = r_cur_x;
    assign o_cur_y      = r_cur_y;

endmodule

// File: tb/tb_pcd8544_spi_receiver.sv
// Bench for pcd8544_spi_receiver: directed init/address/wrap/abort cases then
// randomized traffic, checked against a linear-index model of the display.
module tb_pcd8544_spi_receiver;

    localparam int COLS = 84;
    localparam int ROWS = 6;
    localparam int HALF = 4;
`ifdef PCD_FRAME_DONE_EN
    localparam bit FRAME_EN = 1'b1;
`else
    localparam bit FRAME_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pcd8544_spi_receiver_if spi_if();

    logic [7:0] o_rx_byte;
    logic       o_rx_valid;
    logic       o_rx_is_data;
    logic       o_ram_we;
    logic [8:0] o_ram_addr;
    logic [7:0] o_ram_wdata;
    logic       o_pd;
    logic       o_v_mode;
    logic       o_h_ext;
    logic [1:0] o_disp_mode;
    logic [6:0] o_vop;
    logic [2:0] o_bias;
    logic [1:0] o_tc;
    logic [6:0] o_cur_x;
    logic [2:0] o_cur_y;
    logic       o_frame_done;

    pcd8544_spi_receiver dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .spi          (spi_if),
        .o_rx_byte    (o_rx_byte),
        .o_rx_valid   (o_rx_valid),
        .o_rx_is_data (o_rx_is_data),
        .o_ram_we     (o_ram_we),
        .o_ram_addr   (o_ram_addr),
        .o_ram_wdata  (o_ram_wdata),
        .o_pd         (o_pd),
        .o_v_mode     (o_v_mode),
        .o_h_ext      (o_h_ext),
        .o_disp_mode  (o_disp_mode),
        .o_vop        (o_vop),
        .o_bias       (o_bias),
        .o_tc         (o_tc),
        .o_cur_x      (o_cur_x),
        .o_cur_y      (o_cur_y),
        .o_frame_done (o_frame_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Event monitor sampled on the falling edge
    int         n_rx = 0;
    int         n_we = 0;
    int         n_frame = 0;
    logic [7:0] mon_byte;
    logic       mon_dc;
    logic [8:0] mon_addr;
    logic [7:0] mon_wdata;
    bit         rst_watch = 1'b0;

    always @(negedge clk) begin
        if (o_rx_valid === 1'b1) begin
            n_rx++;
            mon_byte = o_rx_byte;
            mon_dc   = o_rx_is_data;
        end
        if (o_ram_we === 1'b1) begin
            n_we++;
            mon_addr  = o_ram_addr;
            mon_wdata = o_ram_wdata;
        end
        if (o_frame_done === 1'b1) n_frame++;
        if (rst_watch) begin
            check_eq("rst_pd", o_pd, 1);
            check_eq("rst_cur_x", o_cur_x, 0);
            check_eq("rst_cur_y", o_cur_y, 0);
            check_eq("rst_rx_valid", o_rx_valid, 0);
            check_eq("rst_ram_we", o_ram_we, 0);
        end
    end

    // Reference model: cursor treated as a linear index into a 504-byte frame
    int m_pd, m_v, m_h, m_disp, m_vop, m_bias, m_tc, m_x, m_y, m_frame, m_addr;

    task automatic model_reset();
        m_pd = 1; m_v = 0; m_h = 0; m_disp = 0; m_vop = 0;
        m_bias = 0; m_tc = 0; m_x = 0; m_y = 0;
    endtask

    task automatic model_apply(input logic [7:0] b, input logic dc);
        int v;
        int idx;
        v = int'(b);
        if (dc) begin
            m_addr = m_y * COLS + m_x;
            if (m_v == 0) begin
                idx = m_y * COLS + m_x;
                if (idx == COLS * ROWS - 1 && FRAME_EN) m_frame++;
                idx = (idx + 1) % (COLS * ROWS);
                m_x = idx % COLS;
                m_y = idx / COLS;
            end else begin
                idx = m_x * ROWS + m_y;
                if (idx == COLS * ROWS - 1 && FRAME_EN) m_frame++;
                idx = (idx + 1) % (COLS * ROWS);
                m_x = idx / ROWS;
                m_y = idx % ROWS;
            end
        end else if (v >= 128) begin
            if (m_h == 1) m_vop = v - 128;
            else if (v - 128 < COLS) m_x = v - 128;
        end else if (v / 8 == 8) begin
            if (m_h == 0 && v % 8 < ROWS) m_y = v % 8;
        end else if (v / 8 == 4) begin
            m_pd = (v / 4) % 2; m_v = (v / 2) % 2; m_h = v % 2;
        end else if (v / 8 == 2) begin
            if (m_h == 1) m_bias = v % 8;
        end else if (v / 8 == 1 && (v / 2) % 2 == 0) begin
            if (m_h == 0) m_disp = ((v / 4) % 2) * 2 + v % 2;
        end else if (v / 4 == 1) begin
            if (m_h == 1) m_tc = v % 4;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nbits, input logic dc);
        spi_if.sce = 1'b0;
        spi_if.dc  = dc;
        for (int i = 0; i < nbits; i++) begin
            spi_if.mosi = b[7 - i];
            tick(HALF);
            spi_if.sclk = 1'b1;
            tick(HALF);
            spi_if.sclk = 1'b0;
        end
    endtask

    task automatic check_state();
        check_eq("pd", o_pd, m_pd);
        check_eq("v_mode", o_v_mode, m_v);
        check_eq("h_ext", o_h_ext, m_h);
        check_eq("disp_mode", o_disp_mode, m_disp);
        check_eq("vop", o_vop, m_vop);
        check_eq("bias", o_bias, m_bias);
        check_eq("tc", o_tc, m_tc);
        check_eq("cur_x", o_cur_x, m_x);
        check_eq("cur_y", o_cur_y, m_y);
        check_eq("frame_done_cnt", n_frame, m_frame);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc, input bit release_sce);
        int rx0, we0;
        rx0 = n_rx;
        we0 = n_we;
        spi_bits(b, 8, dc);
        if (release_sce) spi_if.sce = 1'b1;
        for (int t = 0; t < 20 && n_rx == rx0; t++) tick(1);
        tick(3);
        model_apply(b, dc);
        check_eq("rx_count", n_rx, rx0 + 1);
        check_eq("rx_byte", mon_byte, b);
        check_eq("rx_is_data", mon_dc, dc);
        check_eq("ram_we_count", n_we, we0 + (dc ? 1 : 0));
        if (dc) begin
            check_eq("ram_addr", mon_addr, m_addr);
            check_eq("ram_wdata", mon_wdata, b);
        end
        check_state();
    endtask

    task automatic abort_after(input logic [7:0] b, input int nbits);
        int rx0;
        rx0 = n_rx;
        spi_bits(b, nbits, 1'b0);
        spi_if.sce = 1'b1;
        tick(8);
        check_eq("abort_no_rx", n_rx, rx0);
    endtask

    initial begin
        int rx0;
        logic [7:0] rb;
        spi_if.sclk = 1'b0;
        spi_if.mosi = 1'b0;
        spi_if.sce  = 1'b1;
        spi_if.dc   = 1'b0;
        m_frame = 0;
        m_addr  = 0;
        model_reset();

        rst = 1'b1;
        @(negedge clk);
        rst_watch = 1'b1;
        tick(10);
        rst_watch = 1'b0;
        rst = 1'b0;
        tick(2);
        check_state();

        // Init sequence
        rx0 = n_rx;
        send_byte(8'h21, 1'b0, 1'b0);
        send_byte(8'hB1, 1'b0, 1'b0);
        send_byte(8'h04, 1'b0, 1'b0);
        send_byte(8'h14, 1'b0, 1'b0);
        send_byte(8'h20, 1'b0, 1'b0);
        send_byte(8'h0C, 1'b0, 1'b1);
        check_eq("init_rx_pulses", n_rx - rx0, 6);

        // Address set and write
        send_byte(8'h42, 1'b0, 1'b0);
        send_byte(8'h85, 1'b0, 1'b0);
        send_byte(8'hAA, 1'b1, 1'b1);

        // Horizontal wrap from the last address
        send_byte(8'hD3, 1'b0, 1'b0);
        send_byte(8'h45, 1'b0, 1'b0);
        send_byte(8'h5A, 1'b1, 1'b1);

        // Vertical wrap of Y only
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h8A, 1'b0, 1'b0);
        send_byte(8'h45, 1'b0, 1'b0);
        send_byte(8'h3C, 1'b1, 1'b1);

        // Vertical wrap from the last address
        send_byte(8'hD3, 1'b0, 1'b0);
        send_byte(8'h45, 1'b0, 1'b0);
        send_byte(8'hC3, 1'b1, 1'b1);
        send_byte(8'h20, 1'b0, 1'b1);

        // Abort, then a full byte; out-of-range cursor commands ignored
        abort_after(8'hFF, 5);
        send_byte(8'h80, 1'b0, 1'b1);
        send_byte(8'h47, 1'b0, 1'b0);
        send_byte(8'hD5, 1'b0, 1'b1);

        // sclk activity while deselected is ignored
        rx0 = n_rx;
        for (int i = 0; i < 10; i++) begin
            spi_if.mosi = 1'b1;
            tick(HALF);
            spi_if.sclk = 1'b1;
            tick(HALF);
            spi_if.sclk = 1'b0;
        end
        tick(6);
        check_eq("sce_high_no_rx", n_rx, rx0);
        send_byte(8'h81, 1'b0, 1'b1);

        // Reset mid-byte discards the partial byte
        spi_bits(8'hFF, 4, 1'b1);
        spi_if.sce = 1'b1;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        model_reset();
        tick(3);
        check_state();
        send_byte(8'h96, 1'b1, 1'b1);

        // Randomized traffic
        for (int k = 0; k < 70; k++) begin
            rb = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 9))
                0: abort_after(rb, $urandom_range(1, 7));
                1, 2, 3, 4: send_byte(rb, 1'b1, 1'($urandom_range(0, 1)));
                5: send_byte(8'(8'h20 | $urandom_range(0, 7)), 1'b0, 1'($urandom_range(0, 1)));
                default: send_byte(rb, 1'b0, 1'($urandom_range(0, 1)));
            endcase
        end

        spi_if.sce = 1'b1;
        tick(4);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
